// File: rtl/arbiter_multiplexer_n_to_1.sv
// Registered N-to-1 multiplexer with per-channel valid/ready handshake and arbitration.
// Define ARBITER_MULTIPLEXER_ROUND_ROBIN_EN for round-robin; otherwise fixed priority (lowest index wins).
module arbiter_multiplexer_n_to_1 #(
    parameter int N_BITS = 32,
    parameter int N_CH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH-1:0]         valid_i,
    input  logic [N_CH*N_BITS-1:0]  data_i,
    output logic [N_CH-1:0]         ready_o,
    output logic                    valid_o,
    output logic [N_BITS-1:0]       data_o,
    output logic [$clog2(N_CH)-1:0] grant_o,
    input  logic                    ready_i
);

    localparam int SEL_BITS = $clog2(N_CH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [N_BITS-1:0]   data_q, data_d;
    logic [SEL_BITS-1:0] grant_q, grant_d;

    logic                load;
    logic                any_req;
    logic [SEL_BITS-1:0] sel;
    logic [N_BITS-1:0]   ch_word [N_CH];

    always_comb begin
        for (int k = 0; k < N_CH; k++) begin
            ch_word[k] = data_i[k*N_BITS +: N_BITS];
        end
    end

`ifdef ARBITER_MULTIPLEXER_ROUND_ROBIN_EN
    logic [SEL_BITS-1:0] ptr_q, ptr_d;

    // Scan from farthest to nearest so the channel closest to ptr is assigned last and wins.
    always_comb begin
        logic [SEL_BITS:0] idx;
        sel     = '0;
        any_req = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + (SEL_BITS+1)'(i);
            if (idx >= (SEL_BITS+1)'(N_CH)) begin
                idx = idx - (SEL_BITS+1)'(N_CH);
            end
            if (valid_i[idx[SEL_BITS-1:0]]) begin
                sel     = idx[SEL_BITS-1:0];
                any_req = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (reset && load && any_req) begin
            ptr_d = (sel == SEL_BITS'(N_CH - 1)) ? '0 : sel + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (valid_i[i]) begin
                sel     = SEL_BITS'(i);
                any_req = 1'b1;
            end
        end
    end
`endif

    assign load = (state_q == ST_EMPTY) || ready_i;

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        ready_o = '0;
        state_d = state_q;
        data_d  = data_q;
        grant_d = grant_q;
        // Gating with reset keeps ready_o low while the block is held in reset.
        if (reset && load) begin
            if (any_req) begin
                ready_o[sel] = 1'b1;
                state_d      = ST_FULL;
                data_d       = ch_word[sel];
                grant_d      = sel;
            end else begin
                state_d = ST_EMPTY;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all of them update together on the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            grant_q <= grant_d;
        end
    end

    assign valid_o = (state_q == ST_FULL);
    assign data_o  = data_q;
    assign grant_o = grant_q;

    a_ready_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(ready_o));
    a_ready_valid:  assert property (@(posedge clk) disable iff (!reset) (ready_o & ~valid_i) == '0);

endmodule
